// File: rtl/cam_pkg.sv
// Shared definitions for the camera stream path.
// Holds the frame-guard FSM state encoding, the padding-mode flag, and the
// skid-buffer sideband width. Parameter-dependent widths stay in the modules.
package cam_pkg;

    // Frame-guard FSM states
    typedef enum logic [1:0] {
        S_WAIT_SOF  = 2'd0,
        S_PASS      = 2'd1,
        S_PAD       = 2'd2,
        S_DROP_LINE = 2'd3
    } state_t;

    // Where padding stops: at the end of the current line, or at the end of the frame
    typedef enum logic {
        PAD_MODE_LINE  = 1'b0,
        PAD_MODE_FRAME = 1'b1
    } pad_mode_t;

    // Sideband bits carried next to TDATA through the skid buffer (TUSER, TLAST)
    localparam int SIDEBAND_BITS = 2;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream register slice.
// Gives full throughput with one cycle of latency. The master-side outputs
// come straight from registers and stay stable while m_valid_o is high and
// m_ready_i is low. s_ready_o is registered (it is just "skid entry empty").
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   s_valid_i/s_ready_o   push side handshake
//   s_data_i              push payload (WIDTH bits)
//   m_valid_o/m_ready_i   pop side handshake
//   m_data_o              pop payload (WIDTH bits)
module axis_skid_buf #(
    parameter int WIDTH = 34
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [WIDTH-1:0] s_data_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;

    // Next-state: refill the output register from skid first, else from input;
    // when the output is stalled, park an incoming beat in the skid entry.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!out_valid_q || m_ready_i) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = s_valid_i;
                out_data_d  = s_valid_i ? s_data_i : out_data_q;
            end
        end else begin
            if (s_valid_i && !skid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = s_data_i;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers; reset throws away anything in flight
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign s_ready_o = !skid_valid_q;
    assign m_valid_o = out_valid_q;
    assign m_data_o  = out_data_q;

endmodule

// File: rtl/axis_frame_guard.sv
// Frame-integrity stage between the camera AXI-stream and the VDMA S2MM slave.
// Locks onto SOF (TUSER) and forces every frame to exactly IMG_W x IMG_H beats.
// Short lines and frames are padded with PAD_VALUE, and excess beats are
// dropped. TUSER and TLAST are regenerated from the internal x/y position.
// Ports:
//   i_clk, i_rst        100 MHz clock, synchronous active-high reset
//   i_enable            forward frames (sampled only between frames)
//   S_AXIS_*            upstream stream (TVALID/TREADY/TDATA/TUSER/TLAST)
//   M_AXIS_*            downstream stream to VDMA, registered via skid buffer
//   o_frame_cnt         frames completed (wraps)
//   o_pad_cnt           padded beats (saturates)
//   o_drop_cnt          dropped beats (saturates)
//   o_locked            high while inside a frame
module axis_frame_guard
    import cam_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    IMG_W      = 640,
    parameter int                    IMG_H      = 480,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_enable,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                  S_AXIS_TUSER,
    input  logic                  S_AXIS_TLAST,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                  M_AXIS_TUSER,
    output logic                  M_AXIS_TLAST,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_pad_cnt,
    output logic [CNT_WIDTH-1:0]  o_drop_cnt,
    output logic                  o_locked
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_MAX = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(IMG_H - 1);
    localparam int PW = DATA_WIDTH + SIDEBAND_BITS;

    // Saturating increment for the pad/drop status counters
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CNT_WIDTH'(1'b1);
        end
    endfunction

    state_t                 state_q, state_d;
    pad_mode_t              pad_mode_q, pad_mode_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [CNT_WIDTH-1:0]   frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]   pad_cnt_q, pad_cnt_d;
    logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;

    logic                   sk_ready_s;
    logic                   emit_s;
    logic [DATA_WIDTH-1:0]  emit_data_s;
    logic                   emit_user_s;
    logic                   emit_last_s;
    logic                   s_ready_s;
    logic                   at_origin_s;
    logic                   x_last_s;
    logic                   y_last_s;
    logic                   sk_m_valid_s;
    logic [PW-1:0]          sk_m_data_s;

    assign at_origin_s = (x_q == '0) && (y_q == '0);
    assign x_last_s    = (x_q == X_MAX);
    assign y_last_s    = (y_q == Y_MAX);

    // FSM next state, upstream ready, skid push, position and status counters
    always_comb begin
        state_d     = state_q;
        pad_mode_d  = pad_mode_q;
        x_d         = x_q;
        y_d         = y_q;
        frame_cnt_d = frame_cnt_q;
        pad_cnt_d   = pad_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        s_ready_s   = 1'b0;
        emit_s      = 1'b0;
        emit_data_s = PAD_VALUE;
        emit_user_s = at_origin_s;
        emit_last_s = x_last_s;

        case (state_q)
            S_WAIT_SOF: begin
                // The SOF beat is held (not consumed) and becomes pixel (0,0) in S_PASS
                if (S_AXIS_TVALID && S_AXIS_TUSER && i_enable) begin
                    s_ready_s = 1'b0;
                    state_d   = S_PASS;
                end else begin
                    s_ready_s = 1'b1;
                    if (S_AXIS_TVALID) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                    end else begin
                        drop_cnt_d = drop_cnt_q;
                    end
                end
            end
            S_PASS: begin
                if (S_AXIS_TVALID && S_AXIS_TUSER && !at_origin_s) begin
                    // Early SOF: leave it upstream and pad out the current frame
                    s_ready_s  = 1'b0;
                    state_d    = S_PAD;
                    pad_mode_d = PAD_MODE_FRAME;
                end else begin
                    s_ready_s = sk_ready_s;
                    if (S_AXIS_TVALID && sk_ready_s) begin
                        emit_s      = 1'b1;
                        emit_data_s = S_AXIS_TDATA;
                        if (x_last_s && !S_AXIS_TLAST) begin
                            state_d = S_DROP_LINE;
                        end else if (!x_last_s && S_AXIS_TLAST) begin
                            state_d    = S_PAD;
                            pad_mode_d = PAD_MODE_LINE;
                        end else begin
                            state_d = S_PASS;
                        end
                    end else begin
                        state_d = S_PASS;
                    end
                end
            end
            S_PAD: begin
                s_ready_s = 1'b0;
                if (sk_ready_s) begin
                    emit_s    = 1'b1;
                    pad_cnt_d = sat_inc(pad_cnt_q);
                    if (x_last_s && (pad_mode_q == PAD_MODE_LINE)) begin
                        state_d = S_PASS;
                    end else begin
                        state_d = S_PAD;
                    end
                end else begin
                    state_d = S_PAD;
                end
            end
            S_DROP_LINE: begin
                if (S_AXIS_TVALID && S_AXIS_TUSER) begin
                    s_ready_s  = 1'b0;
                    state_d    = S_PAD;
                    pad_mode_d = PAD_MODE_FRAME;
                end else begin
                    s_ready_s = 1'b1;
                    if (S_AXIS_TVALID) begin
                        drop_cnt_d = sat_inc(drop_cnt_q);
                        state_d    = S_AXIS_TLAST ? S_PASS : S_DROP_LINE;
                    end else begin
                        state_d = S_DROP_LINE;
                    end
                end
            end
            default: begin
                s_ready_s = 1'b0;
                state_d   = S_WAIT_SOF;
            end
        endcase

        // Position advance; completing the last pixel of a frame overrides the state choice
        if (emit_s) begin
            if (x_last_s) begin
                x_d = '0;
                if (y_last_s) begin
                    y_d         = '0;
                    frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1'b1);
                    state_d     = S_WAIT_SOF;
                end else begin
                    y_d = y_q + YW'(1'b1);
                end
            end else begin
                x_d = x_q + XW'(1'b1);
            end
        end else begin
            x_d = x_q;
        end
    end

    // FSM, position and status registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_WAIT_SOF;
            pad_mode_q  <= PAD_MODE_LINE;
            x_q         <= '0;
            y_q         <= '0;
            frame_cnt_q <= '0;
            pad_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            pad_mode_q  <= pad_mode_d;
            x_q         <= x_d;
            y_q         <= y_d;
            frame_cnt_q <= frame_cnt_d;
            pad_cnt_q   <= pad_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    axis_skid_buf #(
        .WIDTH (PW)
    ) u_skid (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .s_valid_i (emit_s),
        .s_ready_o (sk_ready_s),
        .s_data_i  ({emit_user_s, emit_last_s, emit_data_s}),
        .m_valid_o (sk_m_valid_s),
        .m_ready_i (M_AXIS_TREADY),
        .m_data_o  (sk_m_data_s)
    );

    assign S_AXIS_TREADY = s_ready_s;
    assign M_AXIS_TVALID = sk_m_valid_s;
    assign M_AXIS_TUSER  = sk_m_data_s[PW-1];
    assign M_AXIS_TLAST  = sk_m_data_s[PW-2];
    assign M_AXIS_TDATA  = sk_m_data_s[DATA_WIDTH-1:0];
    assign o_frame_cnt   = frame_cnt_q;
    assign o_pad_cnt     = pad_cnt_q;
    assign o_drop_cnt    = drop_cnt_q;
    assign o_locked      = (state_q != S_WAIT_SOF);

endmodule
